// File: rtl/wbc2pipeline_pkg.sv
// ---------------------------------------------------------------------------
// wbc2pipeline_pkg
//   Shared definitions for the Wishbone classic-to-pipelined bridge:
//   FSM state encoding and the classic cycle-type identifier value.
// ---------------------------------------------------------------------------
package wbc2pipeline_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,   // waiting for a classic strobe
      ST_REQ  = 2'b01,   // o_mstb high, waiting for !i_mstall
      ST_WAIT = 2'b10,   // request accepted, waiting for ack/err
      ST_RESP = 2'b11    // one-cycle upstream ack/err
   } state_t;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;

endpackage

// File: rtl/wbc2pipeline.sv
// ---------------------------------------------------------------------------
// wbc2pipeline
//   Bridge from a Wishbone B4 classic master to a Wishbone B4 pipelined
//   slave. Each classic strobe becomes one registered pipelined request;
//   the downstream ack/err is returned upstream as a single registered pulse.
//   An optional watchdog turns a hung downstream slave into a bus error.
//
// Ports
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_scyc/i_sstb/i_swe         classic cycle, strobe, write enable
//   i_saddr/i_sdata/i_ssel      classic address, write data, byte selects
//   i_scti/i_sbte               cycle-type / burst-type (all treated as classic)
//   o_sack/o_serr/o_sdata       registered response and read data upstream
//   o_mcyc/o_mstb/o_mwe         pipelined cycle, strobe, write enable
//   o_maddr/o_mdata/o_msel      pipelined address, write data, byte selects
//   i_mstall/i_mack/i_merr      pipelined stall, ack, error
//   i_mdata                     pipelined read data
// ---------------------------------------------------------------------------
module wbc2pipeline
   import wbc2pipeline_pkg::*;
#(
   parameter int AW          = 12,
   parameter int DW          = 32,
   parameter int OPT_TIMEOUT = 0,
   parameter int LGTIMEOUT   = 8
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_scyc,
   input  logic            i_sstb,
   input  logic            i_swe,
   input  logic [AW-1:0]   i_saddr,
   input  logic [DW-1:0]   i_sdata,
   input  logic [DW/8-1:0] i_ssel,
   input  logic [2:0]      i_scti,
   input  logic [1:0]      i_sbte,
   output logic            o_sack,
   output logic            o_serr,
   output logic [DW-1:0]   o_sdata,
   output logic            o_mcyc,
   output logic            o_mstb,
   output logic            o_mwe,
   output logic [AW-1:0]   o_maddr,
   output logic [DW-1:0]   o_mdata,
   output logic [DW/8-1:0] o_msel,
   input  logic            i_mstall,
   input  logic            i_mack,
   input  logic            i_merr,
   input  logic [DW-1:0]   i_mdata
);

   localparam int WD_LIM_I = (OPT_TIMEOUT > 0) ? (OPT_TIMEOUT - 1) : 0;
   // Error is raised at the end of the cycle in which the counter shows
   // OPT_TIMEOUT-1, so o_serr appears OPT_TIMEOUT cycles after o_mstb rises.
   localparam logic [LGTIMEOUT-1:0] WD_LIM  = WD_LIM_I[LGTIMEOUT-1:0];
   localparam logic [LGTIMEOUT-1:0] WD_MAX  = {LGTIMEOUT{1'b1}};
   localparam logic [LGTIMEOUT-1:0] WD_ZERO = {LGTIMEOUT{1'b0}};
   localparam logic [LGTIMEOUT-1:0] WD_ONE  = {{(LGTIMEOUT-1){1'b0}}, 1'b1};

   state_t               state_r, state_nx_s;
   logic                 mcyc_nx_s, mstb_nx_s, sack_nx_s, serr_nx_s;
   logic                 latch_s, capture_s;
   logic                 resp_ok_s, timeout_s;
   logic [LGTIMEOUT-1:0] wd_r, wd_nx_s;
   logic                 unused_s;

   // Every cycle type and burst extension is handled as a plain classic cycle.
   assign unused_s = ^{i_scti ^ CTI_CLASSIC, i_sbte};

   // A downstream response counts only once the request has been accepted.
   assign resp_ok_s = (state_r == ST_WAIT) || ((state_r == ST_REQ) && !i_mstall);
   assign timeout_s = (OPT_TIMEOUT > 0) && (wd_r >= WD_LIM);

   // Next-state and next-output decode
   always_comb begin
      state_nx_s = state_r;
      mcyc_nx_s  = o_mcyc;
      mstb_nx_s  = o_mstb;
      sack_nx_s  = 1'b0;
      serr_nx_s  = 1'b0;
      latch_s    = 1'b0;
      capture_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!i_scyc) begin
               mcyc_nx_s = 1'b0;
            end else if (i_sstb) begin
               latch_s    = 1'b1;
               mcyc_nx_s  = 1'b1;
               mstb_nx_s  = 1'b1;
               state_nx_s = ST_REQ;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_REQ, ST_WAIT: begin
            if (!i_scyc) begin
               // Abort: any response in this same cycle is dropped.
               mcyc_nx_s  = 1'b0;
               mstb_nx_s  = 1'b0;
               state_nx_s = ST_IDLE;
            end else if (resp_ok_s && i_merr) begin
               serr_nx_s  = 1'b1;
               mcyc_nx_s  = 1'b0;
               mstb_nx_s  = 1'b0;
               state_nx_s = ST_RESP;
            end else if (resp_ok_s && i_mack) begin
               sack_nx_s  = 1'b1;
               capture_s  = 1'b1;
               mstb_nx_s  = 1'b0;
               state_nx_s = ST_RESP;
            end else if (timeout_s) begin
               serr_nx_s  = 1'b1;
               mcyc_nx_s  = 1'b0;
               mstb_nx_s  = 1'b0;
               state_nx_s = ST_RESP;
            end else if ((state_r == ST_REQ) && !i_mstall) begin
               mstb_nx_s  = 1'b0;
               state_nx_s = ST_WAIT;
            end else begin
               state_nx_s = state_r;
            end
         end
         ST_RESP: begin
            // Never sample a strobe here: the master has not yet seen the ack.
            state_nx_s = ST_IDLE;
            if (!i_scyc) begin
               mcyc_nx_s = 1'b0;
            end else begin
               mcyc_nx_s = o_mcyc;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
            mcyc_nx_s  = 1'b0;
            mstb_nx_s  = 1'b0;
         end
      endcase
   end

   // Watchdog: cleared outside REQ/WAIT, saturating count inside
   always_comb begin
      wd_nx_s = WD_ZERO;
      if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
         if (wd_r != WD_MAX) begin
            wd_nx_s = wd_r + WD_ONE;
         end else begin
            wd_nx_s = wd_r;
         end
      end else begin
         wd_nx_s = WD_ZERO;
      end
   end

   // Control registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_r <= ST_IDLE;
         o_mcyc  <= 1'b0;
         o_mstb  <= 1'b0;
         o_sack  <= 1'b0;
         o_serr  <= 1'b0;
         wd_r    <= WD_ZERO;
      end else begin
         state_r <= state_nx_s;
         o_mcyc  <= mcyc_nx_s;
         o_mstb  <= mstb_nx_s;
         o_sack  <= sack_nx_s;
         o_serr  <= serr_nx_s;
         wd_r    <= wd_nx_s;
      end
   end

   // Request fields and read data; plain data registers without reset
   always_ff @(posedge i_clk) begin
      if (latch_s) begin
         o_mwe   <= i_swe;
         o_maddr <= i_saddr;
         o_mdata <= i_sdata;
         o_msel  <= i_ssel;
      end
      if (capture_s) begin
         o_sdata <= i_mdata;
      end
   end

endmodule
